// File: rtl/tooth_period_capture.sv
// Tooth period capture: measures clocks between tooth edges, finds the missing-tooth gap and tracks tooth index.
// Optional err_cnt output enabled by defining TOOTH_CAP_ERR_CNT_EN.
module tooth_period_capture #(
    parameter int WIDTH       = 24,
    parameter int TOOTH_WIDTH = 8,
    parameter int TOOTH_TOTAL = 58
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   ena,
    input  logic                   cap_edge,
    output logic [WIDTH-1:0]       period_cur,
    output logic [WIDTH-1:0]       period_prev,
    output logic                   period_valid,
    output logic                   gap_det,
    output logic [TOOTH_WIDTH-1:0] tooth_cnt,
    output logic                   sync,
    output logic                   sync_err,
`ifdef TOOTH_CAP_ERR_CNT_EN
    output logic [7:0]             err_cnt,
`endif
    output logic                   ovf
);

    typedef enum logic [1:0] {IDLE, MEASURE, SEARCH, LOCKED} state_t;

    state_t                 state, state_nxt;
    logic [WIDTH-1:0]       cnt, cnt_nxt, cnt_inc;
    logic [WIDTH-1:0]       cur_nxt, prev_nxt;
    logic [TOOTH_WIDTH-1:0] tooth_nxt;
    logic                   valid_nxt, gap_nxt, err_nxt, ovf_nxt;
    logic                   sat, gap_cond, expected;

    assign cnt_inc  = cnt + WIDTH'(1);
    assign sat      = (cnt_inc == {WIDTH{1'b1}});
    // Widened by one bit so old + old/2 cannot wrap for large periods.
    assign gap_cond = {1'b0, cnt_inc} > ({1'b0, period_cur} + {2'b00, period_cur[WIDTH-1:1]});
    assign expected = (tooth_cnt == TOOTH_WIDTH'(TOOTH_TOTAL - 1));

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        cur_nxt   = period_cur;
        prev_nxt  = period_prev;
        tooth_nxt = tooth_cnt;
        valid_nxt = 1'b0;
        gap_nxt   = 1'b0;
        err_nxt   = 1'b0;
        ovf_nxt   = 1'b0;
        if (ena) begin
            if (state != IDLE) cnt_nxt = cnt_inc;
            if (cap_edge) begin
                cnt_nxt = '0;
                if (state != IDLE) begin
                    prev_nxt  = period_cur;
                    cur_nxt   = cnt_inc;
                    valid_nxt = 1'b1;
                end
                case (state)
                    IDLE:    state_nxt = MEASURE;
                    MEASURE: state_nxt = SEARCH;
                    SEARCH: begin
                        if (gap_cond) begin
                            gap_nxt   = 1'b1;
                            tooth_nxt = '0;
                            state_nxt = LOCKED;
                        end
                    end
                    LOCKED: begin
                        gap_nxt = gap_cond;
                        if (gap_cond && expected) begin
                            tooth_nxt = '0;
                        end else if (!gap_cond && !expected) begin
                            tooth_nxt = tooth_cnt + TOOTH_WIDTH'(1);
                        end else begin
                            err_nxt   = 1'b1;
                            tooth_nxt = '0;
                            state_nxt = SEARCH;
                        end
                    end
                    default: state_nxt = IDLE;
                endcase
            end else if (state != IDLE && sat) begin
                // Period too long to represent: drop back and wait for a fresh edge.
                ovf_nxt   = 1'b1;
                err_nxt   = (state == LOCKED);
                tooth_nxt = '0;
                cnt_nxt   = '0;
                state_nxt = IDLE;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            period_cur   <= '0;
            period_prev  <= '0;
            tooth_cnt    <= '0;
            period_valid <= 1'b0;
            gap_det      <= 1'b0;
            sync         <= 1'b0;
            sync_err     <= 1'b0;
            ovf          <= 1'b0;
        end else begin
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            period_cur   <= cur_nxt;
            period_prev  <= prev_nxt;
            tooth_cnt    <= tooth_nxt;
            period_valid <= valid_nxt;
            gap_det      <= gap_nxt;
            sync         <= (state_nxt == LOCKED);
            sync_err     <= err_nxt;
            ovf          <= ovf_nxt;
        end
    end

`ifdef TOOTH_CAP_ERR_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt <= '0;
        end else if ((err_nxt || ovf_nxt) && err_cnt != 8'hFF) begin
            err_cnt <= err_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_tooth_period_capture.sv
// Directed bench: one 24-bit instance for capture/sync/enable behaviour, one 4-bit instance for saturation.
// Expects err_cnt checks when TOOTH_CAP_ERR_CNT_EN is defined.
module tb_tooth_period_capture;

    logic clk = 1'b0;
    logic rst;
    logic ena_a, cap_a, ena_b, cap_b;

    logic [23:0] cur_a, prev_a;
    logic [3:0]  cur_b, prev_b;
    logic [7:0]  tooth_a, tooth_b;
    logic        valid_a, gap_a, sync_a, err_a, ovf_a;
    logic        valid_b, gap_b, sync_b, err_b, ovf_b;
`ifdef TOOTH_CAP_ERR_CNT_EN
    logic [7:0]  errc_a, errc_b;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    tooth_period_capture #(.WIDTH(24), .TOOTH_WIDTH(8), .TOOTH_TOTAL(4)) dut_a (
        .clk(clk), .rst(rst), .ena(ena_a), .cap_edge(cap_a),
        .period_cur(cur_a), .period_prev(prev_a), .period_valid(valid_a),
        .gap_det(gap_a), .tooth_cnt(tooth_a), .sync(sync_a), .sync_err(err_a),
`ifdef TOOTH_CAP_ERR_CNT_EN
        .err_cnt(errc_a),
`endif
        .ovf(ovf_a)
    );

    tooth_period_capture #(.WIDTH(4), .TOOTH_WIDTH(8), .TOOTH_TOTAL(4)) dut_b (
        .clk(clk), .rst(rst), .ena(ena_b), .cap_edge(cap_b),
        .period_cur(cur_b), .period_prev(prev_b), .period_valid(valid_b),
        .gap_det(gap_b), .tooth_cnt(tooth_b), .sync(sync_b), .sync_err(err_b),
`ifdef TOOTH_CAP_ERR_CNT_EN
        .err_cnt(errc_b),
`endif
        .ovf(ovf_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One clock of stimulus; outputs are sampled 1 time unit after the edge.
    task automatic cyc_a(input logic e);
        cap_a = e;
        @(posedge clk);
        #1;
        cap_a = 1'b0;
    endtask

    task automatic ivl_a(input int p);
        repeat (p - 1) cyc_a(1'b0);
        cyc_a(1'b1);
    endtask

    task automatic cyc_b(input logic e);
        cap_b = e;
        @(posedge clk);
        #1;
        cap_b = 1'b0;
    endtask

    initial begin
        rst   = 1'b1;
        ena_a = 1'b1;
        cap_a = 1'b0;
        ena_b = 1'b1;
        cap_b = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        check("rst_cur", 32'(cur_a), 0);
        check("rst_prev", 32'(prev_a), 0);
        check("rst_tooth", 32'(tooth_a), 0);
        check("rst_sync", 32'(sync_a), 0);
        check("rst_valid", 32'(valid_a), 0);
        check("rst_ovf", 32'(ovf_a), 0);
        check("rst_err", 32'(err_a), 0);
        check("rst_gap", 32'(gap_a), 0);

        // First edge only arms measurement.
        cyc_a(1'b1);
        check("first_edge_valid", 32'(valid_a), 0);
        ivl_a(10);
        check("meas_valid", 32'(valid_a), 1);
        check("meas_cur", 32'(cur_a), 10);
        check("meas_prev", 32'(prev_a), 0);
        check("meas_sync", 32'(sync_a), 0);
        check("meas_gap", 32'(gap_a), 0);
        ivl_a(10);
        check("srch_gap", 32'(gap_a), 0);
        check("srch_prev", 32'(prev_a), 10);
        ivl_a(25);
        check("lock_gap", 32'(gap_a), 1);
        check("lock_cur", 32'(cur_a), 25);
        check("lock_tooth", 32'(tooth_a), 0);
        cyc_a(1'b0);
        check("lock_sync", 32'(sync_a), 1);
        check("valid_pulse", 32'(valid_a), 0);
        check("gap_pulse", 32'(gap_a), 0);

        ivl_a(9);
        check("tooth1", 32'(tooth_a), 1);
        ivl_a(10);
        check("tooth2", 32'(tooth_a), 2);
        ivl_a(10);
        check("tooth3", 32'(tooth_a), 3);
        ivl_a(25);
        check("regap_gap", 32'(gap_a), 1);
        check("regap_tooth", 32'(tooth_a), 0);
        check("regap_err", 32'(err_a), 0);
        cyc_a(1'b0);
        check("regap_sync", 32'(sync_a), 1);

        // Early gap at tooth 1 loses sync.
        ivl_a(9);
        check("early_tooth1", 32'(tooth_a), 1);
        ivl_a(25);
        check("early_err", 32'(err_a), 1);
        check("early_gap", 32'(gap_a), 1);
        check("early_tooth", 32'(tooth_a), 0);
        cyc_a(1'b0);
        check("early_sync", 32'(sync_a), 0);
        check("err_pulse", 32'(err_a), 0);
        ivl_a(9);
        check("norelock_gap", 32'(gap_a), 0);
        check("norelock_sync", 32'(sync_a), 0);
        ivl_a(10);
        check("norelock2_sync", 32'(sync_a), 0);
        ivl_a(25);
        check("relock_gap", 32'(gap_a), 1);
        cyc_a(1'b0);
        check("relock_sync", 32'(sync_a), 1);

        // Missing gap at tooth 3 loses sync.
        ivl_a(9);
        ivl_a(10);
        ivl_a(10);
        check("miss_tooth3", 32'(tooth_a), 3);
        ivl_a(10);
        check("miss_err", 32'(err_a), 1);
        check("miss_gap", 32'(gap_a), 0);
        check("miss_tooth", 32'(tooth_a), 0);
        cyc_a(1'b0);
        check("miss_sync", 32'(sync_a), 0);

        // 12 enabled cycles with a 5-cycle disabled stretch holding an ignored edge.
        repeat (3) cyc_a(1'b0);
        ena_a = 1'b0;
        cyc_a(1'b0);
        cyc_a(1'b0);
        cyc_a(1'b1);
        check("ena_edge_valid", 32'(valid_a), 0);
        check("ena_edge_cur", 32'(cur_a), 10);
        cyc_a(1'b0);
        cyc_a(1'b0);
        ena_a = 1'b1;
        repeat (7) cyc_a(1'b0);
        cyc_a(1'b1);
        check("ena_cur", 32'(cur_a), 12);
        check("ena_prev", 32'(prev_a), 10);
        check("ena_valid", 32'(valid_a), 1);

        // Back-to-back edges capture a period of 1.
        cyc_a(1'b1);
        check("b2b_cur", 32'(cur_a), 1);
        check("b2b_prev", 32'(prev_a), 12);
        check("b2b_valid", 32'(valid_a), 1);

        // 4-bit counter: saturation at cnt+1 == 15 with no edge.
        cyc_b(1'b1);
        repeat (4) cyc_b(1'b0);
        cyc_b(1'b1);
        check("b_cur5", 32'(cur_b), 5);
        repeat (14) cyc_b(1'b0);
        check("b_no_ovf_yet", 32'(ovf_b), 0);
        cyc_b(1'b0);
        check("b_ovf", 32'(ovf_b), 1);
        check("b_ovf_sync", 32'(sync_b), 0);
        check("b_ovf_tooth", 32'(tooth_b), 0);
        check("b_ovf_err", 32'(err_b), 0);
        cyc_b(1'b0);
        check("b_ovf_pulse", 32'(ovf_b), 0);
        cyc_b(1'b1);
        check("b_rearm_valid", 32'(valid_b), 0);
        // Edge on the saturating cycle captures all-ones.
        repeat (14) cyc_b(1'b0);
        cyc_b(1'b1);
        check("b_sat_edge_cur", 32'(cur_b), 15);
        check("b_sat_edge_prev", 32'(prev_b), 5);
        check("b_sat_edge_valid", 32'(valid_b), 1);
        check("b_sat_edge_ovf", 32'(ovf_b), 0);

`ifdef TOOTH_CAP_ERR_CNT_EN
        check("a_err_cnt", 32'(errc_a), 2);
        check("b_err_cnt", 32'(errc_b), 1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
